// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle for the four-source round-robin mux arbiter.
// The master side drives requests, source words and downstream ready; the slave side answers.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] data0;
    logic [3:0] data1;
    logic [3:0] data2;
    logic [3:0] data3;
    logic       out_ready;
    logic [3:0] gnt;
    logic       s1;
    logic       s2;
    logic [3:0] out;
    logic       out_valid;
    logic       busy;

    modport master (
        output req, data0, data1, data2, data3, out_ready,
        input  gnt, s1, s2, out, out_valid, busy
    );

    modport slave (
        input  req, data0, data1, data2, data3, out_ready,
        output gnt, s1, s2, out, out_valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 select datapath with bounded bursts and a
// registered valid/ready output stage feeding the ALU input register.
module mux4_rr_arbiter #(
    parameter int BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mux4_rr_arbiter_if.slave         bus
);
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t     r_state,     w_state_nxt;
    logic [1:0] r_owner,     w_owner_nxt;
    logic [1:0] r_ptr,       w_ptr_nxt;
    logic [4:0] r_beat_cnt,  w_beat_cnt_nxt;
    logic [3:0] r_gnt,       w_gnt_nxt;
    logic [3:0] r_out,       w_out_nxt;
    logic       r_out_valid, w_out_valid_nxt;
    logic [3:0] w_data_sel;
    logic [1:0] w_winner;
    logic       w_load;
    logic       w_release;

    // First requester strictly after ptr, wrapping; the previous owner sits last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] ptr_v);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr_v;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_v + 2'(i);
            if (!found && req_v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Select the current owner's word.
    always_comb begin
        w_data_sel = 4'h0;
        case (r_owner)
            2'd0:    w_data_sel = bus.data0;
            2'd1:    w_data_sel = bus.data1;
            2'd2:    w_data_sel = bus.data2;
            2'd3:    w_data_sel = bus.data3;
            default: w_data_sel = 4'h0;
        endcase
    end

    assign w_winner  = rr_pick(bus.req, r_ptr);
    assign w_load    = (r_state == ST_BUSY) && bus.req[r_owner] && (!r_out_valid || bus.out_ready);
    assign w_release = (w_load && (r_beat_cnt == 5'(BURST - 1))) || !bus.req[r_owner];

    // Next-state and datapath decisions.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_ptr_nxt       = r_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_gnt_nxt       = r_gnt;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = 4'b0000;
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
                if (bus.req != 4'b0000) begin
                    w_state_nxt    = ST_BUSY;
                    w_owner_nxt    = w_winner;
                    w_gnt_nxt      = 4'b0001 << w_winner;
                    w_beat_cnt_nxt = 5'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (w_load) begin
                    w_out_nxt       = w_data_sel;
                    w_out_valid_nxt = 1'b1;
                    w_beat_cnt_nxt  = r_beat_cnt + 5'd1;
                end else if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_owner;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State and output registers; ptr resets to 3 so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 2'd0;
            r_ptr       <= 2'd3;
            r_beat_cnt  <= 5'd0;
            r_gnt       <= 4'b0000;
            r_out       <= 4'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_ptr       <= w_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.s1        = r_owner[0];
    assign bus.s2        = r_owner[1];
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state == ST_BUSY);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: a BURST=4 instance for reset, burst, backpressure and early-drop
// scenarios, and a BURST=1 instance for the round-robin grant order.
module tb_mux4_rr_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    mux4_rr_arbiter_if u_if4 ();
    mux4_rr_arbiter_if u_if1 ();

    mux4_rr_arbiter #(.BURST(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));
    mux4_rr_arbiter #(.BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic idle_inputs();
        u_if4.req = 4'b0000; u_if4.out_ready = 1'b1;
        u_if4.data0 = 4'h0; u_if4.data1 = 4'h0; u_if4.data2 = 4'h0; u_if4.data3 = 4'h0;
        u_if1.req = 4'b0000; u_if1.out_ready = 1'b1;
        u_if1.data0 = 4'h4; u_if1.data1 = 4'h5; u_if1.data2 = 4'h6; u_if1.data3 = 4'h7;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state and idle hold with no requests
        check_eq("rst_gnt", 32'(u_if4.gnt), 32'h0);
        check_eq("rst_sel", 32'({u_if4.s2, u_if4.s1}), 32'h0);
        check_eq("rst_out", 32'(u_if4.out), 32'h0);
        check_eq("rst_valid", 32'(u_if4.out_valid), 32'h0);
        tick(); tick();
        check_eq("idle_busy", 32'(u_if4.busy), 32'h0);
        check_eq("idle_gnt", 32'(u_if4.gnt), 32'h0);

        // Single requester on source 1, BURST=4
        u_if4.data1 = 4'hA;
        u_if4.req   = 4'b0010;
        tick(); // N+1
        check_eq("single_gnt", 32'(u_if4.gnt), 32'h2);
        check_eq("single_sel", 32'({u_if4.s2, u_if4.s1}), 32'h1);
        check_eq("single_valid_n1", 32'(u_if4.out_valid), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_eq("single_out", 32'(u_if4.out), 32'hA);
            check_eq("single_valid", 32'(u_if4.out_valid), 32'h1);
        end
        check_eq("single_idle_n5", 32'(u_if4.busy), 32'h0);
        check_eq("single_gnt_n5", 32'(u_if4.gnt), 32'h0);
        tick(); // N+6
        check_eq("single_valid_n6", 32'(u_if4.out_valid), 32'h0);
        check_eq("single_regrant", 32'(u_if4.gnt), 32'h2);
        tick(); // N+7
        check_eq("single_valid_n7", 32'(u_if4.out_valid), 32'h1);
        u_if4.req = 4'b0000;
        tick(); tick();
        check_eq("single_done", 32'(u_if4.busy), 32'h0);

        // Round robin, BURST=1, all four requesting
        do_reset();
        u_if1.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_gnt;
            logic [3:0] exp_out;
            exp_gnt = 4'b0001 << (k % 4);
            exp_out = 4'(4 + (k % 4));
            tick();
            check_eq("rr_gnt", 32'(u_if1.gnt), 32'(exp_gnt));
            tick();
            check_eq("rr_gap", 32'(u_if1.gnt), 32'h0);
            check_eq("rr_out", 32'(u_if1.out), 32'(exp_out));
            check_eq("rr_valid", 32'(u_if1.out_valid), 32'h1);
        end
        u_if1.req = 4'b0000;

        // Backpressure on owner 2
        do_reset();
        u_if4.data2     = 4'h3;
        u_if4.out_ready = 1'b0;
        u_if4.req       = 4'b0100;
        tick();
        check_eq("bp_gnt", 32'(u_if4.gnt), 32'h4);
        check_eq("bp_sel", 32'({u_if4.s2, u_if4.s1}), 32'h2);
        tick();
        check_eq("bp_out", 32'(u_if4.out), 32'h3);
        u_if4.data2 = 4'h9;
        tick(); tick();
        check_eq("bp_hold_out", 32'(u_if4.out), 32'h3);
        check_eq("bp_hold_valid", 32'(u_if4.out_valid), 32'h1);
        u_if4.out_ready = 1'b1;
        tick();
        check_eq("bp_next_out", 32'(u_if4.out), 32'h9);
        tick();
        check_eq("bp_busy_b3", 32'(u_if4.busy), 32'h1);
        tick(); // three beats left after the stall, so release lands here
        check_eq("bp_release", 32'(u_if4.busy), 32'h0);
        check_eq("bp_release_gnt", 32'(u_if4.gnt), 32'h0);
        u_if4.req = 4'b0000;
        tick(); tick();

        // Early drop by owner 3, then source 0 pending
        do_reset();
        u_if4.data3 = 4'h5;
        u_if4.req   = 4'b1000;
        tick(); // N+1
        check_eq("drop_gnt", 32'(u_if4.gnt), 32'h8);
        check_eq("drop_sel", 32'({u_if4.s2, u_if4.s1}), 32'h3);
        tick(); // N+2, second beat loads at the end of this cycle
        tick(); // N+3
        u_if4.req = 4'b0101;
        check_eq("drop_out", 32'(u_if4.out), 32'h5);
        tick(); // N+4 idle bubble
        check_eq("drop_gnt_idle", 32'(u_if4.gnt), 32'h0);
        check_eq("drop_busy_idle", 32'(u_if4.busy), 32'h0);
        tick(); // N+5
        check_eq("drop_next_gnt", 32'(u_if4.gnt), 32'h1);

        // Reset mid-burst with a valid beat held
        do_reset();
        u_if4.req   = 4'b0010;
        u_if4.data1 = 4'hA;
        tick(); tick();
        check_eq("mid_valid_pre", 32'(u_if4.out_valid), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("mid_gnt", 32'(u_if4.gnt), 32'h0);
        check_eq("mid_sel", 32'({u_if4.s2, u_if4.s1}), 32'h0);
        check_eq("mid_out", 32'(u_if4.out), 32'h0);
        check_eq("mid_valid", 32'(u_if4.out_valid), 32'h0);
        check_eq("mid_busy", 32'(u_if4.busy), 32'h0);
        u_if4.req = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        check_eq("mid_first_gnt", 32'(u_if4.gnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Shares one 4-bit 4:1 select datapath between four requesters using round-robin arbitration with bounded bursts.
- Drives the two mux select lines (s1 = select bit 0, s2 = select bit 1) from the current owner and registers the selected 4-bit word into an output stage with valid/ready handshake.
- Sits between the four operand sources and the downstream ALU input register.

Parameters:
- BURST, 4, maximum beats one owner may transfer per grant; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per source; bit i requests transfer of data_i.
- data0  input  4  source 0 word.
- data1  input  4  source 1 word.
- data2  input  4  source 2 word.
- data3  input  4  source 3 word.
- out_ready  input  1  downstream can accept out this cycle.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- s1  output  1  registered select bit 0 = owner[0].
- s2  output  1  registered select bit 1 = owner[1].
- out  output  4  registered selected word.
- out_valid  output  1  out holds an unconsumed beat.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset (async, immediate, any state, including mid-burst):
  - State goes to IDLE; gnt=0, s1=s2=0, out=0, out_valid=0, busy=0.
  - ptr=3, so source 0 has first priority; beat_cnt=0.
- States:
  - IDLE:
    - gnt=0.
    - If req!=0, winner = first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
    - Next cycle: BUSY, owner=winner, gnt=onehot(winner), {s2,s1}=winner, beat_cnt=0.
    - If req==0, stay in IDLE; s1/s2 hold the last owner.
  - BUSY:
    - load = req[owner] && (!out_valid || out_ready).
    - On load: out <= data_owner, sampled at that edge; out_valid <= 1; beat_cnt++.
    - If no load and out_ready: out_valid <= 0. Otherwise out and out_valid hold.
    - Release when (load && beat_cnt==BURST-1) or !req[owner].
    - On release: next state IDLE, gnt <= 0, ptr <= owner, busy <= 0.
- Handshake:
  - A beat is consumed on any cycle with out_valid && out_ready.
  - out is stable while out_valid && !out_ready.
  - In IDLE, out_valid clears on out_ready; out holds its value.
- Latency:
  - req rises in IDLE at cycle N: gnt/s1/s2 valid at N+1, first load at N+1, out_valid at N+2.
  - Each release costs exactly one IDLE bubble cycle before the next grant.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle with the updated ptr.
  - The owner drops req while the last beat is stalled: release proceeds; the held beat remains valid until consumed.
- Fairness: the owner is lowest priority in the next arbitration. With all four requesting, grants go 0,1,2,3,0…
- Data outside the owner's slot is ignored. req changes of non-owners during BUSY have no effect.

Test Plan:
- Reset: assert rst mid-stream -> same cycle gnt=0000, s1=s2=0, out=0, out_valid=0, busy=0. Deassert rst with req=0000 -> stays idle.
- Single requester, BURST=4, req=0010, data1=4'hA, out_ready=1, req rises at N:
  - gnt=0010 and s1=1, s2=0 from N+1; out=A with out_valid=1 on N+2..N+5.
  - IDLE at N+5, out_valid=0 at N+6, re-grant at N+6, out_valid again at N+7.
- Round robin: req=1111, data_i=i+4, out_ready=1, BURST=1 -> gnt sequence 0001,0010,0100,1000,0001 with one idle cycle between grants; out sequence 4,5,6,7,4.
- Backpressure: owner 2, data2=4'h3, out_ready=0 -> out=3, out_valid=1 held. Change data2=4'h9 -> out stays 3 and beat_cnt stays 1. Raise out_ready -> next beat out=9.
- Early drop: owner 3 with BURST=4 drops req after 2 beats -> release next edge, gnt=0. With req=0001 pending -> gnt=0001 after one idle cycle (ptr=3).
- Reset mid-burst: rst while busy with out_valid=1 -> all outputs zero immediately. After release, req=1111 -> source 0 granted first.
